// File: rtl/tile_blitter.sv
// Tile-to-framebuffer copy engine: streams a TILE_W x TILE_H tile out of a pipelined ROM,
// applies flip/clip/colour-key and writes surviving pixels through a backpressured port.
module tile_blitter #(
    parameter int          TILE_W    = 32,
    parameter int          TILE_H    = 32,
    parameter int          ROM_AW    = 19,
    parameter int          ROM_LAT   = 2,
    parameter int          FB_W      = 640,
    parameter int          FB_H      = 480,
    parameter int          FB_AW     = 19,
    parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ROM_AW-1:0] tile_addr,
    input  logic [9:0]        top,
    input  logic [9:0]        left,
    input  logic              flip_x,
    input  logic              flip_y,
    input  logic              transp_en,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [FB_AW-1:0]  dst_addr,
    output logic [15:0]       dst_data,
    output logic              dst_wr,
    input  logic              dst_ready
);

    localparam int CW    = $clog2(TILE_W);
    localparam int RW    = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int DEPTH = ROM_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Job parameters captured at start; the request inputs are free to change afterwards.
    logic [ROM_AW-1:0] base_reg;
    logic [9:0]        top_reg;
    logic [9:0]        left_reg;
    logic              flip_x_reg;
    logic              flip_y_reg;
    logic              transp_reg;
    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_reg;

    logic [CW-1:0]     src_col;
    logic [RW-1:0]     src_row;
    logic [ROM_AW-1:0] read_addr;
    logic [10:0]       dest_x;
    logic [10:0]       dest_y;
    logic              last_pix;
    logic              issue;

    logic [ROM_LAT-1:0] stage_valid;
    logic [10:0]        stage_x [ROM_LAT];
    logic [10:0]        stage_y [ROM_LAT];
    logic [CNTW-1:0]    inflight;

    logic [FB_AW-1:0] fifo_addr [DEPTH];
    logic [15:0]      fifo_data [DEPTH];
    logic             fifo_skip [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CNTW-1:0]  fifo_count_reg;

    logic              push;
    logic              pop;
    logic [10:0]       push_x;
    logic [10:0]       push_y;
    logic              push_skip;
    logic [FB_AW-1:0]  push_addr;
    logic              head_valid;
    logic              head_skip;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Source coordinates after mirroring; TILE_W is a power of two so row*TILE_W is a concat.
    assign src_col   = flip_x_reg ? (CW'(TILE_W - 1) - col_reg) : col_reg;
    assign src_row   = flip_y_reg ? (RW'(TILE_H - 1) - row_reg) : row_reg;
    assign read_addr = base_reg + ROM_AW'({src_row, src_col});
    assign dest_x    = 11'(left_reg) + 11'(col_reg);
    assign dest_y    = 11'(top_reg) + 11'(row_reg);
    assign last_pix  = (col_reg == CW'(TILE_W - 1)) && (row_reg == RW'(TILE_H - 1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNTW'(stage_valid[i]);
        end
    end

    assign head_valid = (fifo_count_reg != '0);
    assign head_skip  = fifo_skip[rd_ptr_reg];
    assign pop        = head_valid && (head_skip || dst_ready);

    // Credit check: every read in flight plus every queued entry (less the one leaving now)
    // must still fit in the FIFO once this new read lands.
    assign issue = (state_reg == S_RUN) &&
                   ((32'(inflight) + 32'(fifo_count_reg)) < (32'(DEPTH) + 32'(pop)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        rom_addr   = '0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                rom_addr = read_addr;
                if (issue && last_pix) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((inflight == '0) &&
                    ((fifo_count_reg == '0) || ((fifo_count_reg == CNTW'(1)) && pop))) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_reg   <= '0;
            top_reg    <= '0;
            left_reg   <= '0;
            flip_x_reg <= 1'b0;
            flip_y_reg <= 1'b0;
            transp_reg <= 1'b0;
            col_reg    <= '0;
            row_reg    <= '0;
        end else if ((state_reg == S_IDLE) && start) begin
            base_reg   <= tile_addr;
            top_reg    <= top;
            left_reg   <= left;
            flip_x_reg <= flip_x;
            flip_y_reg <= flip_y;
            transp_reg <= transp_en;
            col_reg    <= '0;
            row_reg    <= '0;
        end else if (issue) begin
            col_reg <= col_reg + CW'(1);
            if (col_reg == CW'(TILE_W - 1)) begin
                row_reg <= row_reg + RW'(1);
            end
        end
    end

    // Destination tags travel with each read so they meet the ROM word on arrival.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_valid <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                stage_x[i] <= '0;
                stage_y[i] <= '0;
            end
        end else begin
            stage_valid[0] <= issue;
            stage_x[0]     <= dest_x;
            stage_y[0]     <= dest_y;
            for (int i = 1; i < ROM_LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_x[i]     <= stage_x[i-1];
                stage_y[i]     <= stage_y[i-1];
            end
        end
    end

    assign push      = stage_valid[ROM_LAT-1];
    assign push_x    = stage_x[ROM_LAT-1];
    assign push_y    = stage_y[ROM_LAT-1];
    assign push_skip = (32'(push_x) >= 32'(FB_W)) || (32'(push_y) >= 32'(FB_H)) ||
                       (transp_reg && (rom_data == KEY_COLOR));
    assign push_addr = FB_AW'(32'(push_y) * 32'(FB_W) + 32'(push_x));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_reg] <= push_addr;
            fifo_data[wr_ptr_reg] <= rom_data;
            fifo_skip[wr_ptr_reg] <= push_skip;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNTW'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CNTW'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Head of queue drives the write port directly, so it holds steady through stalls.
    assign dst_wr   = head_valid && !head_skip;
    assign dst_addr = dst_wr ? fifo_addr[rd_ptr_reg] : '0;
    assign dst_data = dst_wr ? fifo_data[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_tile_blitter.sv
// Bench for tile_blitter: pipelined ROM model, per-tile expected write list built from the
// pixel rules, a negedge monitor comparing every accepted write, plus literal spot checks.
module tb_tile_blitter;
    localparam int TW  = 4;
    localparam int TH  = 2;
    localparam int LAT = 2;
    localparam int AW  = 19;
    localparam int FBW = 640;
    localparam int FBH = 480;
    localparam int FAW = 19;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] tile_addr;
    logic [9:0]    top;
    logic [9:0]    left;
    logic          flip_x;
    logic          flip_y;
    logic          transp_en;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [FAW-1:0] dst_addr;
    logic [15:0]   dst_data;
    logic          dst_wr;
    logic          dst_ready;

    tile_blitter #(
        .TILE_W(TW), .TILE_H(TH), .ROM_AW(AW), .ROM_LAT(LAT),
        .FB_W(FBW), .FB_H(FBH), .FB_AW(FAW), .KEY_COLOR(16'hF81F)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .tile_addr(tile_addr), .top(top), .left(left),
        .flip_x(flip_x), .flip_y(flip_y), .transp_en(transp_en), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .dst_addr(dst_addr), .dst_data(dst_data),
        .dst_wr(dst_wr), .dst_ready(dst_ready)
    );

    typedef struct packed {
        logic [FAW-1:0] a;
        logic [15:0]    d;
    } wr_t;

    logic [15:0] rom_mem [64];
    logic [15:0] rom_d1;
    wr_t         exp_q[$];
    wr_t         got_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          done_cnt   = 0;
    int          done_cyc   = 0;
    bit          rand_ready = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle ROM: data is valid LAT cycles after the address is presented.
    always @(posedge clk) begin
        rom_d1   <= rom_mem[rom_addr[5:0]];
        rom_data <= rom_d1;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        dst_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic rom_default();
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'h0100 + 16'(i);
    endtask

    // Expected writes straight from the pixel rules: walk the tile, mirror, clip, key.
    task automatic build_expected(input int base, input int l, input int t,
                                  input bit fx, input bit fy, input bit tr);
        exp_q.delete();
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) begin
                int sr, sc, x, y;
                logic [15:0] colr;
                sr   = fy ? TH - 1 - r : r;
                sc   = fx ? TW - 1 - c : c;
                colr = rom_mem[(base + sr * TW + sc) % 64];
                x    = l + c;
                y    = t + r;
                if (x < FBW && y < FBH && !(tr && colr == 16'hF81F))
                    exp_q.push_back('{a: FAW'(y * FBW + x), d: colr});
            end
        end
    endtask

    // Monitor: every accepted write against the model, plus hold-under-stall and done rules.
    initial begin
        bit             prev_stall;
        logic [FAW-1:0] prev_a;
        logic [15:0]    prev_d;
        wr_t            e;
        prev_stall = 0;
        prev_a     = '0;
        prev_d     = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                check("hold_wr", 64'(dst_wr), 64'd1);
                check("hold_addr", 64'(dst_addr), 64'(prev_a));
                check("hold_data", 64'(dst_data), 64'(prev_d));
            end
            if (dst_wr && dst_ready) begin
                got_q.push_back('{a: dst_addr, d: dst_data});
                $display("write addr=%0d data=%04h", dst_addr, dst_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_queue", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(dst_addr), 64'(e.a));
                    check("wr_data", 64'(dst_data), 64'(e.d));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", 64'(busy), 64'd0);
            end
            prev_stall = dst_wr && !dst_ready;
            prev_a     = dst_addr;
            prev_d     = dst_data;
        end
    end

    task automatic check_got(input string name, input int idx,
                             input logic [FAW-1:0] a, input logic [15:0] d);
        if (idx < got_q.size()) begin
            check({name, "_addr"}, 64'(got_q[idx].a), 64'(a));
            check({name, "_data"}, 64'(got_q[idx].d), 64'(d));
        end else begin
            check({name, "_present"}, 64'(got_q.size()), 64'(idx + 1));
        end
    endtask

    task automatic issue_start(input int base, input int l, input int t,
                               input bit fx, input bit fy, input bit tr, output int ts);
        got_q.delete();
        build_expected(base, l, t, fx, fy, tr);
        @(posedge clk);
        #1;
        tile_addr = AW'(base);
        left      = 10'(l);
        top       = 10'(t);
        flip_x    = fx;
        flip_y    = fy;
        transp_en = tr;
        start     = 1'b1;
        @(posedge clk);
        #1;
        ts    = cyc;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        tile_addr = AW'($urandom);
        left      = 10'($urandom);
        top       = 10'($urandom);
        flip_x    = ~fx;
        flip_y    = ~fy;
        transp_en = ~tr;
    endtask

    task automatic run_blit(input string name, input int base, input int l, input int t,
                            input bit fx, input bit fy, input bit tr, output int lat);
        int ts, d0;
        d0 = done_cnt;
        issue_start(base, l, t, fx, fy, tr, ts);
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        check({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
        lat = done_cyc - ts;
        repeat (4) @(negedge clk);
        #1;
        check({name, "_model_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_busy_idle"}, 64'(busy), 64'd0);
        $display("%s: %0d writes, done %0d cycles after start accepted", name, got_q.size(), lat);
    endtask

    initial begin
        int lat, ts, d0, hits;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ts, d0, hits;
        rom_default();
        start = 0; tile_addr = '0; top = '0; left = '0;
        flip_x = 0; flip_y = 0; transp_en = 0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dst_wr", 64'(dst_wr), 64'd0);
        check("rst_dst_addr", 64'(dst_addr), 64'd0);
        check("rst_dst_data", 64'(dst_data), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;

        // 1: plain copy
        run_blit("t1", 0, 10, 5, 0, 0, 0, lat);
        check("t1_write_count", 64'(got_q.size()), 64'd8);
        check_got("t1_first", 0, 19'd3210, 16'h0100);
        check_got("t1_fifth", 4, 19'd3850, 16'h0104);
        check_got("t1_last", 7, 19'd3853, 16'h0107);
        check("t1_latency_bound", 64'(lat <= TW * TH + LAT + 2), 64'd1);

        // 2: both flips
        run_blit("t2", 0, 10, 5, 1, 1, 0, lat);
        check("t2_write_count", 64'(got_q.size()), 64'd8);
        check_got("t2_first", 0, 19'd3210, 16'h0107);
        check_got("t2_last", 7, 19'd3853, 16'h0100);

        // 3: colour key on words 2 and 5
        rom_mem[2] = 16'hF81F;
        rom_mem[5] = 16'hF81F;
        run_blit("t3", 0, 10, 5, 0, 0, 1, lat);
        check("t3_write_count", 64'(got_q.size()), 64'd6);
        hits = 0;
        foreach (got_q[i]) if (got_q[i].a == 19'd3212 || got_q[i].a == 19'd3851) hits++;
        check("t3_keyed_absent", 64'(hits), 64'd0);
        rom_default();

        // 4: bottom-right corner clipping
        run_blit("t4", 0, 638, 479, 0, 0, 0, lat);
        check("t4_write_count", 64'(got_q.size()), 64'd2);
        check_got("t4_first", 0, 19'd307198, 16'h0100);
        check_got("t4_second", 1, 19'd307199, 16'h0101);

        // 5: random backpressure
        rand_ready = 1;
        run_blit("t5", 0, 10, 5, 0, 0, 0, lat);
        rand_ready = 0;
        check("t5_write_count", 64'(got_q.size()), 64'd8);
        check_got("t5_first", 0, 19'd3210, 16'h0100);
        check_got("t5_last", 7, 19'd3853, 16'h0107);

        // 6: reset after the third write, then a fresh job
        d0 = done_cnt;
        issue_start(0, 10, 5, 0, 0, 0, ts);
        for (int i = 0; i < 100 && got_q.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        check("t6_three_writes", 64'(got_q.size()), 64'd3);
        rstn = 1'b0;
        #1;
        check("t6_abort_dst_wr", 64'(dst_wr), 64'd0);
        check("t6_abort_dst_addr", 64'(dst_addr), 64'd0);
        check("t6_abort_dst_data", 64'(dst_data), 64'd0);
        check("t6_abort_busy", 64'(busy), 64'd0);
        check("t6_abort_rom_addr", 64'(rom_addr), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t6_no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        check("t6_no_writes_after_abort", 64'(got_q.size()), 64'd3);
        run_blit("t6b", 0, 10, 5, 0, 0, 0, lat);
        check("t6b_write_count", 64'(got_q.size()), 64'd8);
        check_got("t6b_first", 0, 19'd3210, 16'h0100);
        check_got("t6b_last", 7, 19'd3853, 16'h0107);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
